// File: rtl/ge_p2_dbl.sv
// Point doubling on ed25519 in the ge_p2 -> ge_p1p1 form, with one shared field squarer.
// ge_p2_dbl_fe_mul multiplies ref10 field elements (10 signed limbs, radix 2^25.5).
module ge_p2_dbl_fe_mul (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [319:0] f_i,
   input  logic [319:0] g_i,
   output logic         done_o,
   output logic [319:0] h_o
);
   logic signed [63:0] acc_q [10];
   logic signed [63:0] acc_d [10];
   logic signed [63:0] hc [10];
   logic [3:0]         cnt_q;
   logic               busy_q, fin_q, done_q;
   logic [319:0]       h_q;
   logic [319:0]       h_d;

   function automatic logic signed [63:0] sext(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic int carry_limb(input int s);
      case (s)
         0: return 0;  1: return 4;  2: return 1;  3: return 5;
         4: return 2;  5: return 6;  6: return 3;  7: return 7;
         8: return 4;  9: return 8;  10: return 9; default: return 0;
      endcase
   endfunction

   // One row of partial products per cycle: f limb cnt_q times every g limb.
   always_comb begin
      logic signed [63:0] fe, p;
      int k;
      for (int j = 0; j < 10; j++) acc_d[j] = acc_q[j];
      fe = sext(f_i[{cnt_q, 5'd0} +: 32]);
      for (int j = 0; j < 10; j++) begin
         p = fe * sext(g_i[j*32 +: 32]);
         if (cnt_q[0] && (j % 2 == 1)) p = p <<< 1;
         k = int'(cnt_q) + j;
         if (k >= 10) begin
            p = p * 64'sd19;
            k = k - 10;
         end
         acc_d[k] = acc_d[k] + p;
      end
   end

   // ref10 carry sequence; limb 9 wraps into limb 0 with a factor of 19.
   always_comb begin
      logic signed [63:0] c;
      int i, w;
      for (int j = 0; j < 10; j++) hc[j] = acc_q[j];
      for (int s = 0; s < 12; s++) begin
         i = carry_limb(s);
         w = (i % 2 == 1) ? 25 : 26;
         c = (hc[i] + (64'sd1 <<< (w - 1))) >>> w;
         hc[i] = hc[i] - (c <<< w);
         if (i == 9) hc[0] = hc[0] + c * 64'sd19;
         else        hc[i+1] = hc[i+1] + c;
      end
      h_d = '0;
      for (int j = 0; j < 10; j++) h_d[j*32 +: 32] = hc[j][31:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < 10; j++) acc_q[j] <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         fin_q  <= 1'b0;
         done_q <= 1'b0;
         h_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            for (int j = 0; j < 10; j++) acc_q[j] <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            fin_q  <= 1'b0;
         end else if (busy_q) begin
            for (int j = 0; j < 10; j++) acc_q[j] <= acc_d[j];
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               busy_q <= 1'b0;
               fin_q  <= 1'b1;
            end
         end else if (fin_q) begin
            h_q    <= h_d;
            done_q <= 1'b1;
            fin_q  <= 1'b0;
         end
      end
   end

   assign done_o = done_q;
   assign h_o    = h_q;
endmodule

module ge_p2_dbl (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic         done,
   input  logic [319:0] p_X,
   input  logic [319:0] p_Y,
   input  logic [319:0] p_Z,
   output logic [319:0] r_X,
   output logic [319:0] r_Y,
   output logic [319:0] r_Z,
   output logic [319:0] r_T
);
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      SQX_S   = 4'd1,
      SQX_W   = 4'd2,
      SQY_S   = 4'd3,
      SQY_W   = 4'd4,
      SQZ_S   = 4'd5,
      SQZ_W   = 4'd6,
      SQB_S   = 4'd7,
      SQB_W   = 4'd8,
      COMBINE = 4'd9,
      DONE    = 4'd10
   } state_t;

   state_t       state_q, state_d;
   logic [319:0] x_q, y_q, z_q, s_q, xx_q, yy_q, zz_q, b_q;
   logic [319:0] rx_q, ry_q, rz_q, rt_q;
   logic [319:0] s_d, ry_d, rz_d, rx_d, zz2_d, rt_d;
   logic [319:0] mul_op, mul_h;
   logic         mul_start, mul_done;

   // All field add/sub is limb-wise with 32-bit wrap; no carries between limbs.
   for (genvar gi = 0; gi < 10; gi++) begin : g_limb
      assign s_d[gi*32 +: 32]   = p_X[gi*32 +: 32] + p_Y[gi*32 +: 32];
      assign ry_d[gi*32 +: 32]  = yy_q[gi*32 +: 32] + xx_q[gi*32 +: 32];
      assign rz_d[gi*32 +: 32]  = yy_q[gi*32 +: 32] - xx_q[gi*32 +: 32];
      assign rx_d[gi*32 +: 32]  = b_q[gi*32 +: 32] - ry_d[gi*32 +: 32];
      assign zz2_d[gi*32 +: 32] = zz_q[gi*32 +: 32] + zz_q[gi*32 +: 32];
      assign rt_d[gi*32 +: 32]  = zz2_d[gi*32 +: 32] - rz_d[gi*32 +: 32];
   end

   ge_p2_dbl_fe_mul u_mul (
      .clk     (clk),
      .reset   (reset),
      .start_i (mul_start),
      .f_i     (mul_op),
      .g_i     (mul_op),
      .done_o  (mul_done),
      .h_o     (mul_h)
   );

   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      mul_op    = '0;
      case (state_q)
         IDLE:    if (start) state_d = SQX_S;
         SQX_S:   begin mul_start = 1'b1; mul_op = x_q; state_d = SQX_W; end
         SQX_W:   begin mul_op = x_q; if (mul_done) state_d = SQY_S; end
         SQY_S:   begin mul_start = 1'b1; mul_op = y_q; state_d = SQY_W; end
         SQY_W:   begin mul_op = y_q; if (mul_done) state_d = SQZ_S; end
         SQZ_S:   begin mul_start = 1'b1; mul_op = z_q; state_d = SQZ_W; end
         SQZ_W:   begin mul_op = z_q; if (mul_done) state_d = SQB_S; end
         SQB_S:   begin mul_start = 1'b1; mul_op = s_q; state_d = SQB_W; end
         SQB_W:   begin mul_op = s_q; if (mul_done) state_d = COMBINE; end
         COMBINE: state_d = DONE;
         DONE:    if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q  <= '0; y_q  <= '0; z_q  <= '0; s_q <= '0;
         xx_q <= '0; yy_q <= '0; zz_q <= '0; b_q <= '0;
         rx_q <= '0; ry_q <= '0; rz_q <= '0; rt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            x_q <= p_X;
            y_q <= p_Y;
            z_q <= p_Z;
            s_q <= s_d;
         end
         if (mul_done) begin
            if (state_q == SQX_W) xx_q <= mul_h;
            if (state_q == SQY_W) yy_q <= mul_h;
            if (state_q == SQZ_W) zz_q <= mul_h;
            if (state_q == SQB_W) b_q  <= mul_h;
         end
         if (state_q == COMBINE) begin
            rx_q <= rx_d;
            ry_q <= ry_d;
            rz_q <= rz_d;
            rt_q <= rt_d;
         end
      end
   end

   assign done = (state_q == DONE);
   assign r_X  = rx_q;
   assign r_Y  = ry_q;
   assign r_Z  = rz_q;
   assign r_T  = rt_q;
endmodule

// File: tb/tb_ge_p2_dbl.sv
// Directed vectors for ge_p2_dbl with hand-computed ge_p1p1 results.
module tb_ge_p2_dbl;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         done;
   logic [319:0] p_X = '0, p_Y = '0, p_Z = '0;
   logic [319:0] r_X, r_Y, r_Z, r_T;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           mul_starts = 0;

   always #5 clk = ~clk;

   ge_p2_dbl dut (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .p_X(p_X), .p_Y(p_Y), .p_Z(p_Z),
      .r_X(r_X), .r_Y(r_Y), .r_Z(r_Z), .r_T(r_T)
   );

   always @(posedge clk) if (dut.mul_start) mul_starts <= mul_starts + 1;

   function automatic logic [319:0] limb(input int idx, input logic [31:0] v);
      logic [319:0] r;
      r = '0;
      r[idx*32 +: 32] = v;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else
         $display("ok   %s", tag);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, {319'b0, done}, {319'b0, 1'b1});
   endtask

   task automatic check_r(input string tag, input logic [319:0] ex, ey, ez, et);
      chk({tag, "_rX"}, r_X, ex);
      chk({tag, "_rY"}, r_Y, ey);
      chk({tag, "_rZ"}, r_Z, ez);
      chk({tag, "_rT"}, r_T, et);
   endtask

   task automatic run(input string tag, input logic [319:0] x, y, z,
                      input logic [319:0] ex, ey, ez, et);
      int s0;
      @(negedge clk);
      s0 = mul_starts;
      p_X = x; p_Y = y; p_Z = z;
      start = 1'b1;
      wait_done(tag);
      check_r(tag, ex, ey, ez, et);
      chk({tag, "_muls"}, {288'b0, 32'(mul_starts - s0)}, {288'b0, 32'd4});
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [319:0] sm_x, sm_y, sm_z, sm_t;
      logic [3:0]   st;
      int           s0, n;
      sm_x = limb(0, 32'd12);
      sm_y = limb(0, 32'd13);
      sm_z = limb(0, 32'd5);
      sm_t = limb(0, 32'hFFFFFFFD);

      repeat (3) @(negedge clk);
      chk("rst_done", {319'b0, done}, '0);
      check_r("rst", '0, '0, '0, '0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_no_mul", {288'b0, 32'(mul_starts)}, '0);

      run("ident", '0, limb(0, 1), limb(0, 1), '0, limb(0, 1), limb(0, 1), limb(0, 1));
      run("small", limb(0, 2), limb(0, 3), limb(0, 1), sm_x, sm_y, sm_z, sm_t);
      run("l9", limb(9, 1), '0, '0, '0, limb(8, 38), limb(8, 32'hFFFFFFDA), limb(8, 38));
      run("cross", limb(1, 1), limb(0, 1), '0, limb(1, 2),
          limb(0, 1) | limb(2, 2), limb(0, 1) | limb(2, 32'hFFFFFFFE),
          limb(0, 32'hFFFFFFFF) | limb(2, 2));
      run("carry", limb(0, 32'd8192), '0, '0, '0, limb(1, 1), limb(1, 32'hFFFFFFFF), limb(1, 1));

      // Held start must not retrigger.
      @(negedge clk);
      s0 = mul_starts;
      p_X = limb(0, 2); p_Y = limb(0, 3); p_Z = limb(0, 1);
      start = 1'b1;
      wait_done("hold");
      repeat (50) @(negedge clk);
      chk("hold_done", {319'b0, done}, {319'b0, 1'b1});
      chk("hold_muls", {288'b0, 32'(mul_starts - s0)}, {288'b0, 32'd4});
      start = 1'b0;
      @(negedge clk);
      chk("hold_release", {319'b0, done}, '0);
      run("rerun", limb(0, 2), limb(0, 3), limb(0, 1), sm_x, sm_y, sm_z, sm_t);

      // Input change after the start edge is ignored.
      @(negedge clk);
      p_X = limb(0, 2); p_Y = limb(0, 3); p_Z = limb(0, 1);
      start = 1'b1;
      @(negedge clk);
      p_X = limb(0, 7);
      p_Z = limb(3, 5);
      wait_done("chg");
      check_r("chg", sm_x, sm_y, sm_z, sm_t);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Reset while squaring Z.
      @(negedge clk);
      s0 = mul_starts;
      p_X = limb(0, 2); p_Y = limb(0, 3); p_Z = limb(0, 1);
      start = 1'b1;
      n = 0;
      while (mul_starts - s0 < 3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_reach", {288'b0, 32'(mul_starts - s0)}, {288'b0, 32'd3});
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      st = dut.state_q;
      chk("mid_state", {316'b0, st}, '0);
      chk("mid_done", {319'b0, done}, '0);
      check_r("mid_rst", '0, '0, '0, '0);
      reset = 1'b1;
      s0 = mul_starts;
      repeat (5) @(negedge clk);
      chk("mid_no_mul", {288'b0, 32'(mul_starts - s0)}, '0);
      run("after_rst", limb(0, 2), limb(0, 3), limb(0, 1), sm_x, sm_y, sm_z, sm_t);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ge_p2_dbl.md
GE_P2_DBL -- requirements
Module: ge_p2_dbl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 start  input  1  level request; a rising level while IDLE begins one doubling.
REQ-005 done  output  1  result valid; held until start is low.
REQ-006 p_X, p_Y, p_Z  input  320 each  ge_p2 operand; field element as 10 signed 32-bit limbs, limb i = bits [32i+31:32i].
REQ-007 r_X, r_Y, r_Z, r_T  output  320 each  ge_p1p1 result, in the same limb format; feeds ge_p1p1_to_p2.

Function
REQ-008 SHALL compute r = 2p:
- XX = X^2, YY = Y^2, ZZ = Z^2, B = (X+Y)^2
- r_Y = YY+XX, r_Z = YY-XX, r_X = B-r_Y, r_T = 2*ZZ - r_Z
REQ-009 All squarings SHALL use one internal fe_mul instance with f = g. fe_mul handshake:
- start: 1-cycle pulse.
- done: 1-cycle pulse when h is valid.
- latency: arbitrary, at least 1 cycle.
REQ-010 Field add/sub SHALL be limb-wise 32-bit two's-complement wrap, with no carry propagation or reduction. X+Y SHALL also be limb-wise. 2*ZZ SHALL be ZZ+ZZ limb-wise.
REQ-011 FSM states SHALL be: IDLE, SQX_S, SQX_W, SQY_S, SQY_W, SQZ_S, SQZ_W, SQB_S, SQB_W, COMBINE, DONE.
REQ-012 IDLE transitions:
- start=1 -> SQX_S.
- On that same edge, p_X/p_Y/p_Z and X+Y SHALL be latched into internal registers.
- The computation SHALL use only the latched values; later input changes are ignored.
REQ-013 Each *_S state SHALL assert the mul start for exactly one cycle, hold its operand selected, and go to the matching *_W state.
REQ-014 Each *_W state SHALL:
- hold its operand stable;
- on mul done, capture h into XX/YY/ZZ/B respectively;
- advance SQX_W->SQY_S->SQZ_S->SQB_S->COMBINE.
REQ-015 COMBINE SHALL register all four outputs from the captured products in one cycle, then go to DONE.
REQ-016 done SHALL be 1 exactly in the cycles the FSM is in DONE.
REQ-017 DONE SHALL go to IDLE when start=0. It SHALL stay in DONE while start=1, so a held start never triggers a second run.
REQ-018 r_* SHALL remain unchanged from COMBINE until the next COMBINE.
REQ-019 Latency SHALL be 6 + sum of the four fe_mul latencies, counted in cycles from the start-sampling edge to done=1.
REQ-020 Unused encodings SHALL go to IDLE on the next edge.
REQ-021 start changes outside IDLE and DONE SHALL be ignored.

Reset
REQ-022 reset=0 SHALL drive state to IDLE and clear done, r_X, r_Y, r_Z, r_T, XX, YY, ZZ, B and the latched inputs to 0. This SHALL apply at any point, including mid-multiplication.
REQ-023 The fe_mul instance SHALL share the same reset.
REQ-024 After reset release, no mul start SHALL be issued until a new start is sampled in IDLE.

Verification
REQ-025 Identity case: p = (X=0, Y=1, Z=1), values in limb0, other limbs 0 -> done=1 with r_X=0, r_Y=1, r_Z=1, r_T=1.
REQ-026 Small values: p = (2, 3, 1) in limb0 -> r_X=12, r_Y=13, r_Z=5, r_T limb0 = 0xFFFFFFFD (-3), other limbs 0.
REQ-027 Held start: start held high for 50 cycles past done -> done stays 1, exactly 4 mul starts total; start low then high -> a second run with exactly 4 more mul starts.
REQ-028 Input change mid-run: change p_X one cycle after start is sampled -> outputs still match the values latched at start.
REQ-029 Reset mid-run: assert reset during SQZ_W -> next cycle done=0, all r_*=0, state IDLE; a subsequent run with p = (2, 3, 1) gives the REQ-026 values.
REQ-030 Chained check: feed r_* into ge_p1p1_to_p2 -> its result matches a software ref10 ge_p2_dbl + ge_p1p1_to_p2 for 100 random on-curve points.
